// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: packed digit/dp/blanking inputs from the
// datapath and the active-low anode/segment outputs toward the board pins.
interface seg_scan_driver_if #(
   parameter int N_DIGITS = 4
);
   logic [4*N_DIGITS-1:0] bcd;
   logic [N_DIGITS-1:0]   dp;
   logic                  blank_lz;
   logic [N_DIGITS-1:0]   an;
   logic [6:0]            seg;
   logic                  dp_n;
   logic                  frame_done;

   modport master (
      output bcd, dp, blank_lz,
      input  an, seg, dp_n, frame_done
   );

   modport slave (
      input  bcd, dp, blank_lz,
      output an, seg, dp_n, frame_done
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with a frame-coherent shadow of the
// display value, leading-zero blanking, per-digit dp and an anti-ghosting blank slot.
module seg_scan_driver #(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 2,
   parameter int HEX_MODE     = 0
) (
   input  logic             clk,
   input  logic             rst,
   seg_scan_driver_if.slave bus
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
   localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

   logic [DIV_W-1:0]      div;
   logic [IDX_W-1:0]      idx;
   logic                  prime;
   logic [4*N_DIGITS-1:0] sh_bcd;
   logic [N_DIGITS-1:0]   sh_dp;
   logic                  sh_lz;

   logic [N_DIGITS-1:0]   an_q;
   logic [6:0]            seg_q;
   logic                  dp_n_q;
   logic                  frame_done_q;

   logic                  div_tc;
   logic                  frame_end;
   logic                  shadow_load;
   logic                  blank_phase;
   logic [N_DIGITS-1:0]   lz_blank;
   logic                  seen_nz;
   logic [N_DIGITS-1:0]   an_nxt;
   logic [6:0]            seg_nxt;
   logic                  dp_n_nxt;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = (HEX_MODE != 0) ? 7'h08 : 7'h3F;
         4'hB: s = (HEX_MODE != 0) ? 7'h03 : 7'h3F;
         4'hC: s = (HEX_MODE != 0) ? 7'h46 : 7'h3F;
         4'hD: s = (HEX_MODE != 0) ? 7'h21 : 7'h3F;
         4'hE: s = (HEX_MODE != 0) ? 7'h06 : 7'h3F;
         default: s = (HEX_MODE != 0) ? 7'h0E : 7'h3F;
      endcase
      return s;
   endfunction

   assign div_tc      = (div == DIV_TC);
   assign frame_end   = div_tc && (idx == IDX_LAST);
   assign shadow_load = prime || frame_end;

   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign blank_phase = 1'b0;
      end else begin : g_blank
         assign blank_phase = (div < BLANK_END);
      end
   endgenerate

   // Scan from the most significant digit down; a digit is blanked while no
   // nonzero digit has been seen at or above it. Digit 0 always shows.
   always_comb begin
      seen_nz  = 1'b0;
      lz_blank = '0;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         seen_nz     = seen_nz | (|sh_bcd[4*k +: 4]);
         lz_blank[k] = sh_lz & ~seen_nz & (k != 0);
      end
   end

   always_comb begin
      an_nxt   = '1;
      seg_nxt  = 7'h7F;
      dp_n_nxt = 1'b1;
      if (!blank_phase) begin
         for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
               an_nxt[k] = 1'b0;
               seg_nxt   = lz_blank[k] ? 7'h7F : decode(sh_bcd[4*k +: 4]);
               dp_n_nxt  = ~sh_dp[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div          <= '0;
         idx          <= '0;
         prime        <= 1'b1;
         sh_bcd       <= '0;
         sh_dp        <= '0;
         sh_lz        <= 1'b0;
         an_q         <= '1;
         seg_q        <= 7'h7F;
         dp_n_q       <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         if (div_tc) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            div <= div + 1'b1;
         end
         prime <= 1'b0;
         if (shadow_load) begin
            sh_bcd <= bus.bcd;
            sh_dp  <= bus.dp;
            sh_lz  <= bus.blank_lz;
         end
         an_q         <= an_nxt;
         seg_q        <= seg_nxt;
         dp_n_q       <= dp_n_nxt;
         frame_done_q <= frame_end;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp_n       = dp_n_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: three configurations driven side by side and compared
// cycle by cycle against an arithmetic model of the scan schedule and shadow loads.
module tb_seg_scan_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [15:0] bcd4;
   logic [3:0]  dp4;
   logic        lz4;
   logic [31:0] bcd8;
   logic [7:0]  dp8;
   logic        lz8;

   seg_scan_driver_if #(.N_DIGITS(4)) bus_a ();
   seg_scan_driver_if #(.N_DIGITS(4)) bus_b ();
   seg_scan_driver_if #(.N_DIGITS(8)) bus_c ();

   assign bus_a.bcd = bcd4;  assign bus_a.dp = dp4;  assign bus_a.blank_lz = lz4;
   assign bus_b.bcd = bcd4;  assign bus_b.dp = dp4;  assign bus_b.blank_lz = lz4;
   assign bus_c.bcd = bcd8;  assign bus_c.dp = dp8;  assign bus_c.blank_lz = lz8;

   seg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0)) u_dec (
      .clk(clk), .rst(rst), .bus(bus_a.slave));
   seg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1)) u_hex (
      .clk(clk), .rst(rst), .bus(bus_b.slave));
   seg_scan_driver #(.N_DIGITS(8), .SCAN_DIV(5), .BLANK_CYCLES(0), .HEX_MODE(1)) u_oct (
      .clk(clk), .rst(rst), .bus(bus_c.slave));

   int vectors = 0;
   int miscompares = 0;
   int m = 0;

   int nd [3] = '{4, 4, 8};
   int sd [3] = '{4, 4, 5};
   int bl [3] = '{1, 1, 0};
   int hx [3] = '{0, 1, 1};

   logic [31:0] msh [3];
   logic [7:0]  mdp [3];
   logic        mlz [3];
   logic [6:0]  seg_tab [16];

   function automatic logic [6:0] dec(input int v, input int hex);
      if (v > 9 && hex == 0) return 7'h3F;
      return seg_tab[v];
   endfunction

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      assert (act === exp) else begin
         miscompares++;
         $error("FAIL %s m=%0d observed=%h expected=%h", tag, m, act, exp);
      end
   endtask

   task automatic tick();
      logic        rst_s;
      logic [31:0] in_b [3];
      logic [7:0]  in_d [3];
      logic        in_l [3];
      logic [7:0]  ean [3];
      logic [6:0]  eseg [3];
      logic        edp [3];
      logic        efd [3];
      @(posedge clk);
      rst_s = rst;
      in_b[0] = {16'h0, bcd4}; in_d[0] = {4'h0, dp4}; in_l[0] = lz4;
      in_b[1] = {16'h0, bcd4}; in_d[1] = {4'h0, dp4}; in_l[1] = lz4;
      in_b[2] = bcd8;          in_d[2] = dp8;         in_l[2] = lz8;
      if (rst_s) m = 0;
      else m++;
      for (int d = 0; d < 3; d++) begin
         logic [7:0] mask;
         int n, div, idx, frame, dig;
         logic blank;
         mask  = 8'((32'd1 << nd[d]) - 1);
         frame = nd[d] * sd[d];
         ean[d] = mask; eseg[d] = 7'h7F; edp[d] = 1'b1; efd[d] = 1'b0;
         if (rst_s) begin
            msh[d] = '0; mdp[d] = '0; mlz[d] = 1'b0;
         end else begin
            n   = m - 1;
            div = n % sd[d];
            idx = (n / sd[d]) % nd[d];
            if (div >= bl[d]) begin
               dig      = int'((msh[d] >> (4 * idx)) & 32'hF);
               blank    = mlz[d] && idx > 0 && ((msh[d] >> (4 * idx)) == 0);
               ean[d]   = mask & ~(8'd1 << idx);
               eseg[d]  = blank ? 7'h7F : dec(dig, hx[d]);
               edp[d]   = ~mdp[d][idx];
            end
            efd[d] = (m % frame) == 0;
            if (m == 1 || (m % frame) == 0) begin
               msh[d] = in_b[d]; mdp[d] = in_d[d]; mlz[d] = in_l[d];
            end
         end
      end
      #1;
      check("dec.an",   8'(bus_a.an),         ean[0]);
      check("dec.seg",  8'(bus_a.seg),        8'(eseg[0]));
      check("dec.dp_n", 8'(bus_a.dp_n),       8'(edp[0]));
      check("dec.fd",   8'(bus_a.frame_done), 8'(efd[0]));
      check("hex.an",   8'(bus_b.an),         ean[1]);
      check("hex.seg",  8'(bus_b.seg),        8'(eseg[1]));
      check("hex.dp_n", 8'(bus_b.dp_n),       8'(edp[1]));
      check("hex.fd",   8'(bus_b.frame_done), 8'(efd[1]));
      check("oct.an",   bus_c.an,             ean[2]);
      check("oct.seg",  8'(bus_c.seg),        8'(eseg[2]));
      check("oct.dp_n", 8'(bus_c.dp_n),       8'(edp[2]));
      check("oct.fd",   8'(bus_c.frame_done), 8'(efd[2]));
   endtask

   task automatic run(input int c);
      repeat (c) tick();
   endtask

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      for (int d = 0; d < 3; d++) begin
         msh[d] = '0; mdp[d] = '0; mlz[d] = 1'b0;
      end
      bcd4 = 16'h0; dp4 = 4'h0; lz4 = 1'b0;
      bcd8 = 32'h0; dp8 = 8'h0; lz8 = 1'b0;

      // reset state
      rst = 1'b1;
      run(3);

      // basic 1234 scan, decimal point off
      bcd4 = 16'h1234; dp4 = 4'h0; lz4 = 1'b0;
      bcd8 = 32'h8765_4321; dp8 = 8'h0; lz8 = 1'b0;
      rst = 1'b0;
      run(43);

      // change mid slot 2: current frame must keep 1234
      bcd4 = 16'h5678;
      bcd8 = 32'h0BAD_F00D; dp8 = 8'hA5;
      run(40);

      // leading-zero blanking with a decimal point on digit 2
      bcd4 = 16'h0070; lz4 = 1'b1; dp4 = 4'b0100;
      bcd8 = 32'h0000_0300; lz8 = 1'b1; dp8 = 8'h10;
      run(36);
      bcd4 = 16'h0000; dp4 = 4'h0;
      bcd8 = 32'h0;
      run(36);

      // nibbles above 9: dash versus hex letters
      bcd4 = 16'hAF00; lz4 = 1'b0;
      bcd8 = 32'hFEDC_BA98; lz8 = 1'b0; dp8 = 8'h0;
      run(36);

      // randomized values, some with leading zeros, changing at random points
      for (int i = 0; i < 30; i++) begin
         bcd4 = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
         dp4  = 4'($urandom);
         lz4  = 1'($urandom);
         bcd8 = $urandom & (32'hFFFF_FFFF >> (4 * $urandom_range(0, 7)));
         dp8  = 8'($urandom);
         lz8  = 1'($urandom);
         run($urandom_range(1, 30));
      end

      // one-cycle reset mid slot 3, then restart with freshly primed input
      for (int i = 0; i < 16 && !(((m / 4) % 4) == 3 && (m % 4) == 2); i++) tick();
      bcd4 = 16'h9876; dp4 = 4'b0001; lz4 = 1'b0;
      bcd8 = 32'h1357_9BDF; dp8 = 8'h80; lz8 = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run(48);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
